mips_step_ctrl: RTL



---
 rtl/mips_step_ctrl_pkg.sv | 13 +
 rtl/mips_step_ctrl_if.sv | 21 ++
 rtl/mips_step_ctrl_debounce.sv | 49 ++++
 rtl/mips_step_ctrl.sv | 89 ++++++++
 4 files changed

// File: rtl/mips_step_ctrl_pkg.sv
// Shared encodings and default timing constants for the MIPS run-control block.
package mips_ctrl_pkg;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  localparam int unsigned DEF_DIV_COUNT       = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int unsigned DEF_CNT_WIDTH       = 16;

endpackage

// File: rtl/mips_step_ctrl_if.sv
// Board-side signal bundle of the run-control block: switches and button in, enables and LEDs out.
interface mips_step_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic [1:0]           mode;
  logic                 step_btn;
  logic                 tick;
  logic [CNT_WIDTH-1:0] tick_cnt;
  logic                 heartbeat;
  logic                 step_armed;

  modport master (
    output mode, step_btn,
    input  tick, tick_cnt, heartbeat, step_armed
  );

  modport slave (
    input  mode, step_btn,
    output tick, tick_cnt, heartbeat, step_armed
  );
endinterface

// File: rtl/mips_step_ctrl_debounce.sv
// Two-flop synchroniser and stability-counter debouncer for the step push-button.
module step_debounce
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic db_level_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level is accepted only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_level_o = db_q;

endmodule

// File: rtl/mips_step_ctrl.sv
// Run-control for the multicycle MIPS core: selects halt/step/slow/fast and emits a one-cycle tick.
module mips_step_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned DIV_COUNT       = DEF_DIV_COUNT,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  mips_step_ctrl_if.slave  bus
);

  localparam logic [1:0]  ST_HALT = MODE_HALT;
  localparam logic [1:0]  ST_STEP = MODE_STEP;
  localparam logic [1:0]  ST_SLOW = MODE_SLOW;
  localparam logic [1:0]  ST_FAST = MODE_FAST;
  localparam int unsigned DW      = $clog2(DIV_COUNT);

  logic [1:0]           mode_s1_q, mode_s2_q;
  logic [1:0]           state_q, state_d;
  logic                 change;
  logic [DW-1:0]        div_q, div_d;
  logic                 tick_q, tick_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 hb_q, hb_d;
  logic                 prev_q;
  logic                 db_level;

  step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .btn_i     (bus.step_btn),
    .db_level_o(db_level)
  );

  // A state change suppresses the tick and restarts the divider, so every mode
  // starts from a clean phase; the SLOW tick is raised one count early so the
  // registered pulse lines up with divider == DIV_COUNT-1.
  always_comb begin
    state_d = mode_s2_q;
    change  = (state_d != state_q);
    div_d   = '0;
    tick_d  = 1'b0;
    if (!change) begin
      case (state_q)
        ST_STEP: tick_d = db_level && !prev_q;
        ST_SLOW: begin
          tick_d = (div_q == DW'(DIV_COUNT - 2));
          div_d  = (div_q == DW'(DIV_COUNT - 1)) ? '0 : div_q + 1'b1;
        end
        ST_FAST: tick_d = 1'b1;
        default: tick_d = 1'b0;
      endcase
    end
    cnt_d = cnt_q + CNT_WIDTH'(tick_d);
    hb_d  = hb_q ^ tick_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_s1_q <= MODE_HALT;
      mode_s2_q <= MODE_HALT;
      state_q   <= ST_HALT;
      div_q     <= '0;
      tick_q    <= 1'b0;
      cnt_q     <= '0;
      hb_q      <= 1'b0;
      prev_q    <= 1'b1;
    end else begin
      mode_s1_q <= bus.mode;
      mode_s2_q <= mode_s1_q;
      state_q   <= state_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      hb_q      <= hb_d;
      prev_q    <= db_level;
    end
  end

  assign bus.tick       = tick_q;
  assign bus.tick_cnt   = cnt_q;
  assign bus.heartbeat  = hb_q;
  assign bus.step_armed = (state_q == ST_STEP) && !db_level;

endmodule
